// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller with deferred branch flush, held exceptions,
// a post-redirect fetch-kill window and a saturating stall-cycle counter.
module pipe_ctrl_gen #(
  parameter int NUM_STAGES     = 6,
  parameter int BR_STAGE       = 2,
  parameter int EXC_STAGE      = 4,
  parameter int REFETCH_CYCLES = 2,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  br_flush_req,
  input  logic                  ds_valid,
  input  logic                  ds_fetched,
  input  logic                  exc_req,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  fetch_kill,
  output logic                  exc_pending,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DS_WAIT = 2'd1,
    REFETCH = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [3:0]            rf_cnt_r, rf_cnt_nxt_s;
  logic                  exc_pending_r, exc_pending_nxt_s;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [NUM_STAGES-1:0] base_stall_s, upper_stall_s, bubble_s;
  logic [NUM_STAGES-1:0] br_mask_s, ctrl_flush_s;
  logic                  older_block_s, exc_active_s, exc_apply_s, fetch_kill_s;
  logic                  acc_s;

  // Cumulative stall from the oldest stage down, plus the stall-induced bubbles.
  always_comb begin
    base_stall_s  = '0;
    upper_stall_s = '0;
    bubble_s      = '0;
    br_mask_s     = '0;
    acc_s         = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      upper_stall_s[i] = acc_s;
      acc_s            = acc_s | stall_req[i];
      base_stall_s[i]  = acc_s;
    end
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      bubble_s[i] = base_stall_s[i] & ~base_stall_s[i+1];
    end
    for (int i = 0; i < NUM_STAGES; i++) begin
      br_mask_s[i] = (i <= BR_STAGE - 2);
    end
  end

  // A held exception is older than any new one, so exc_req is ignored while held.
  assign older_block_s = base_stall_s[EXC_STAGE+1];
  assign exc_active_s  = exc_req | exc_pending_r;
  assign exc_apply_s   = exc_active_s & ~older_block_s;

  // Control-flow flush mask and fetch kill derived from FSM state.
  always_comb begin
    ctrl_flush_s = '0;
    fetch_kill_s = 1'b0;
    if (exc_apply_s) begin
      ctrl_flush_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (br_flush_req) begin
            ctrl_flush_s = br_mask_s;
          end else begin
            ctrl_flush_s = '0;
          end
        end
        DS_WAIT: ctrl_flush_s = br_mask_s;
        REFETCH: begin
          if (rf_cnt_r != 4'd0) begin
            fetch_kill_s    = 1'b1;
            ctrl_flush_s[0] = 1'b1;
          end else begin
            fetch_kill_s = 1'b0;
          end
        end
        default: ctrl_flush_s = '0;
      endcase
    end
  end

  // Final stall/flush per stage: exception > control flush > stall bubble.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (exc_apply_s && (i <= EXC_STAGE)) begin
        stall_o[i] = 1'b0;
        flush_o[i] = 1'b1;
      end else if (ctrl_flush_s[i]) begin
        // Only a stall from an older stage may keep a flushed stage held.
        stall_o[i] = upper_stall_s[i];
        flush_o[i] = 1'b1;
      end else begin
        stall_o[i] = base_stall_s[i];
        flush_o[i] = bubble_s[i];
      end
    end
  end

  // Next-state, refetch window counter and exception hold logic.
  always_comb begin
    state_nxt_s       = state_r;
    rf_cnt_nxt_s      = rf_cnt_r;
    exc_pending_nxt_s = exc_pending_r;
    if (exc_apply_s) begin
      state_nxt_s       = REFETCH;
      rf_cnt_nxt_s      = 4'(REFETCH_CYCLES);
      exc_pending_nxt_s = 1'b0;
    end else begin
      exc_pending_nxt_s = exc_active_s;
      case (state_r)
        IDLE: begin
          if (br_flush_req && !ds_valid) begin
            state_nxt_s = DS_WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DS_WAIT: begin
          if (ds_fetched && !stall_o[BR_STAGE-1]) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DS_WAIT;
          end
        end
        REFETCH: begin
          if (rf_cnt_r == 4'd0) begin
            state_nxt_s = IDLE;
          end else if (!stall_o[0]) begin
            rf_cnt_nxt_s = rf_cnt_r - 4'd1;
            if (rf_cnt_r == 4'd1) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = REFETCH;
            end
          end else begin
            state_nxt_s = REFETCH;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, refetch counter and held-exception registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= IDLE;
      rf_cnt_r      <= 4'd0;
      exc_pending_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      rf_cnt_r      <= rf_cnt_nxt_s;
      exc_pending_r <= exc_pending_nxt_s;
    end
  end

  // Saturating count of cycles with any stage held; clear beats increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_r <= '0;
    end else if (cnt_clr) begin
      stall_cnt_r <= '0;
    end else if ((|stall_o) && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign fetch_kill  = fetch_kill_s;
  assign exc_pending = exc_pending_r;
  assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen (6 stages, 4-bit stall counter).
module tb_pipe_ctrl_gen;

  logic       clk;
  logic       resetn;
  logic [5:0] stall_req;
  logic       br_flush_req, ds_valid, ds_fetched, exc_req, cnt_clr;
  logic [5:0] stall_o, flush_o;
  logic       fetch_kill, exc_pending;
  logic [3:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] f;
    logic       k;
    logic       p;
    logic [3:0] c;
  } exp_t;

  exp_t sb_q[$];

  pipe_ctrl_gen #(
    .NUM_STAGES(6), .BR_STAGE(2), .EXC_STAGE(4), .REFETCH_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .resetn(resetn), .stall_req(stall_req), .br_flush_req(br_flush_req),
    .ds_valid(ds_valid), .ds_fetched(ds_fetched), .exc_req(exc_req), .cnt_clr(cnt_clr),
    .stall_o(stall_o), .flush_o(flush_o), .fetch_kill(fetch_kill),
    .exc_pending(exc_pending), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, queue expected outputs, compare mid-cycle.
  task automatic cyc(input logic [5:0] sr, input logic br, input logic dv, input logic df,
                     input logic exc, input logic clr,
                     input logic [5:0] es, input logic [5:0] ef, input logic ek, input logic ep);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    stall_req = sr; br_flush_req = br; ds_valid = dv; ds_fetched = df;
    exc_req = exc; cnt_clr = clr;
    e.s = es; e.f = ef; e.k = ek; e.p = ep; e.c = 4'(exp_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_eq("stall_o",     32'(stall_o),     32'(g.s));
      check_eq("flush_o",     32'(flush_o),     32'(g.f));
      check_eq("fetch_kill",  32'(fetch_kill),  32'(g.k));
      check_eq("exc_pending", 32'(exc_pending), 32'(g.p));
      check_eq("stall_cnt",   32'(stall_cnt),   32'(g.c));
    end
    if (clr) exp_cnt = 0;
    else if (es != 6'd0 && exp_cnt != 15) exp_cnt = exp_cnt + 1;
  endtask

  initial begin
    resetn = 1'b0; stall_req = 6'd0; br_flush_req = 1'b0; ds_valid = 1'b0;
    ds_fetched = 1'b0; exc_req = 1'b0; cnt_clr = 1'b0;
    #12;
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_flush", 32'(flush_o), 32'd0);
    check_eq("rst_kill",  32'(fetch_kill), 32'd0);
    check_eq("rst_pend",  32'(exc_pending), 32'd0);
    check_eq("rst_cnt",   32'(stall_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single-cycle stall at stage 3: bubble behind it.
    cyc(6'b001000, 0,0,0, 0,0, 6'b001111, 6'b001000, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Branch flush with delay slot present: one cycle only.
    cyc(6'b000000, 1,1,0, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Branch flush waiting for the delay slot: 4 flush cycles, then IDLE.
    cyc(6'b000000, 1,0,0, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 1,0,0, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 0,0,1, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Exception blocked by writeback stall for 2 cycles, then applied.
    cyc(6'b100000, 0,0,0, 1,0, 6'b111111, 6'b000000, 0, 0);
    cyc(6'b100000, 0,0,0, 0,0, 6'b111111, 6'b000000, 0, 1);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b011111, 0, 1);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 1, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 1, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Exception during DS_WAIT together with a branch: exception wins.
    cyc(6'b000000, 1,0,0, 0,0, 6'b000000, 6'b000001, 0, 0);
    cyc(6'b000000, 1,0,0, 1,0, 6'b000000, 6'b011111, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 1, 0);
    // New exception in REFETCH reloads the window.
    cyc(6'b000000, 0,0,0, 1,0, 6'b000000, 6'b011111, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 1, 0);
    // Stall from stage 1 freezes the window countdown.
    cyc(6'b000010, 0,0,0, 0,0, 6'b000011, 6'b000011, 1, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000001, 1, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Continuous stall: counter saturates, then clear wins.
    for (int i = 0; i < 20; i++) begin
      cyc(6'b000001, 0,0,0, 0,0, 6'b000001, 6'b000001, 0, 0);
    end
    check_eq("cnt_sat_model", 32'(exp_cnt), 32'd15);
    cyc(6'b000001, 0,0,0, 0,1, 6'b000001, 6'b000001, 0, 0);
    cyc(6'b000001, 0,0,0, 0,0, 6'b000001, 6'b000001, 0, 0);
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);
    // Reset asserted mid-REFETCH with an exception held.
    cyc(6'b000000, 0,0,0, 1,0, 6'b000000, 6'b011111, 0, 0);
    cyc(6'b100000, 0,0,0, 1,0, 6'b111111, 6'b000001, 1, 0);
    @(posedge clk);
    #1;
    stall_req = 6'd0; exc_req = 1'b0;
    check_eq("pre_rst_pend", 32'(exc_pending), 32'd1);
    check_eq("pre_rst_kill", 32'(fetch_kill), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_stall", 32'(stall_o), 32'd0);
    check_eq("mid_rst_flush", 32'(flush_o), 32'd0);
    check_eq("mid_rst_kill",  32'(fetch_kill), 32'd0);
    check_eq("mid_rst_pend",  32'(exc_pending), 32'd0);
    check_eq("mid_rst_cnt",   32'(stall_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    exp_cnt = 0;
    cyc(6'b000000, 0,0,0, 0,0, 6'b000000, 6'b000000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
